// File: rtl/generic_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// generic_bus_arbiter_pkg
// Shared types and widths for the two-requester generic bus arbiter.
//   bus_arb_state_t : arbiter FSM encoding (IDLE / GRANT0 / GRANT1)
//   ARB_*_W         : bus field widths (data width scales with BLOCK_SIZE)
//   arb_cnt_w()     : timeout counter width for a given cycle limit
// Optional feature macro used by the arbiter: GENERIC_BUS_ARB_TIMEOUT_EN
// ---------------------------------------------------------------------------
package generic_bus_arbiter_pkg;

    localparam int unsigned ARB_WORD_W = 32;
    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_BE_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } bus_arb_state_t;

    // Width needed to count 0 .. cycles-1, never narrower than one bit.
    function automatic int unsigned arb_cnt_w(input int unsigned cycles);
        return (cycles < 32'd2) ? 32'd1 : 32'($clog2(cycles));
    endfunction

endpackage

// File: rtl/generic_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// generic_bus_arbiter_if
// Generic memory bus between a master (cpu modport) and a slave
// (generic_bus modport).
//   addr/ren/wen/wdata/byte_en : master -> slave request fields
//   rdata/busy/error           : slave -> master response fields
// BLOCK_SIZE words per transfer; all attached instances must agree.
// ---------------------------------------------------------------------------
interface generic_bus_arbiter_if #(
    parameter int unsigned BLOCK_SIZE = 1
);
    import generic_bus_arbiter_pkg::*;

    localparam int unsigned DATA_W = ARB_WORD_W * BLOCK_SIZE;

    logic [ARB_ADDR_W-1:0] addr;
    logic                  ren;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [ARB_BE_W-1:0]   byte_en;
    logic [DATA_W-1:0]     rdata;
    logic                  busy;
    logic                  error;

    // Slave view: receives requests, returns the response.
    modport generic_bus (
        input  addr, ren, wen, wdata, byte_en,
        output rdata, busy, error
    );

    // Master view: issues requests, receives the response.
    modport cpu (
        output addr, ren, wen, wdata, byte_en,
        input  rdata, busy, error
    );
endinterface

// File: rtl/generic_bus_arbiter_timeout_counter.sv
// ---------------------------------------------------------------------------
// generic_bus_arbiter_timeout_counter
// Counts downstream busy cycles of the current grant and flags the cycle on
// which the owner has waited LIMIT busy cycles. Present only when
// GENERIC_BUS_ARB_TIMEOUT_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : hold count at zero (arbiter idle)
//   enable_i   : downstream busy during a grant
//   expired_c  : combinational, last allowed busy cycle reached
// ---------------------------------------------------------------------------
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
module generic_bus_arbiter_timeout_counter
    import generic_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);
    localparam int unsigned CNT_W = arb_cnt_w(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = enable_i & (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/generic_bus_arbiter.sv
// ---------------------------------------------------------------------------
// generic_bus_arbiter
// Shares one downstream generic bus port between a fetch-side (req0) and a
// data-side (req1) master. Round-robin on ties, one whole transaction per
// grant, one idle arbitration cycle between grants.
//   CLK         : system clock, rising edge
//   nRST        : asynchronous active-low reset
//   req0        : requester 0 (fetch side), slave modport
//   req1        : requester 1 (data side), slave modport
//   out         : shared downstream port, master modport
//   grant_owner : current/last owner index (registered)
// Optional macro GENERIC_BUS_ARB_TIMEOUT_EN adds a busy timeout of
// TIMEOUT_CYCLES cycles that aborts the grant with an error to the owner.
// ---------------------------------------------------------------------------
module generic_bus_arbiter
    import generic_bus_arbiter_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 1
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                        CLK,
    input  logic                        nRST,
    generic_bus_arbiter_if.generic_bus  req0,
    generic_bus_arbiter_if.generic_bus  req1,
    generic_bus_arbiter_if.cpu          out,
    output logic                        grant_owner
);
    localparam int unsigned DATA_W = ARB_WORD_W * BLOCK_SIZE;

    bus_arb_state_t    state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              req0_act_c, req1_act_c;
    logic              expired_c;
    logic [DATA_W-1:0] rdata_c;

    assign req0_act_c  = req0.ren | req0.wen;
    assign req1_act_c  = req1.ren | req1.wen;
    assign rdata_c     = out.rdata;
    assign grant_owner = owner_q;

`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
    logic timeout_clr_c;
    logic timeout_en_c;

    // Count is held at zero while idle, so every grant starts from zero.
    assign timeout_clr_c = (state_q == ARB_IDLE);
    assign timeout_en_c  = (state_q != ARB_IDLE) & out.busy;

    generic_bus_arbiter_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (CLK),
        .rst_n     (nRST),
        .clear_i   (timeout_clr_c),
        .enable_i  (timeout_en_c),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    // State, round-robin pointer and owner registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

    // Next-state: arbitrate in IDLE, leave a grant on completion/abort/timeout.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0_act_c && req1_act_c) begin
                    state_d = last_grant_q ? ARB_GRANT0 : ARB_GRANT1;
                end else if (req0_act_c) begin
                    state_d = ARB_GRANT0;
                end else if (req1_act_c) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0: begin
                if (!req0_act_c || !out.busy || expired_c) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            ARB_GRANT1: begin
                if (!req1_act_c || !out.busy || expired_c) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (state_d == ARB_GRANT0) begin
            owner_d = 1'b0;
        end else if (state_d == ARB_GRANT1) begin
            owner_d = 1'b1;
        end
    end

    // Outputs: owner is passed straight through; everyone else sees busy.
    // ren&wen together is treated as a write, so ren is masked by wen.
    always_comb begin
        out.addr    = '0;
        out.ren     = 1'b0;
        out.wen     = 1'b0;
        out.wdata   = '0;
        out.byte_en = '0;
        req0.rdata  = '0;
        req0.busy   = 1'b1;
        req0.error  = 1'b0;
        req1.rdata  = '0;
        req1.busy   = 1'b1;
        req1.error  = 1'b0;
        unique case (state_q)
            ARB_GRANT0: begin
                out.addr    = req0.addr;
                out.ren     = req0.ren & ~req0.wen & ~expired_c;
                out.wen     = req0.wen & ~expired_c;
                out.wdata   = req0.wdata;
                out.byte_en = req0.byte_en;
                req0.rdata  = rdata_c;
                req0.busy   = out.busy & ~expired_c;
                req0.error  = (out.error & ~out.busy) | expired_c;
            end
            ARB_GRANT1: begin
                out.addr    = req1.addr;
                out.ren     = req1.ren & ~req1.wen & ~expired_c;
                out.wen     = req1.wen & ~expired_c;
                out.wdata   = req1.wdata;
                out.byte_en = req1.byte_en;
                req1.rdata  = rdata_c;
                req1.busy   = out.busy & ~expired_c;
                req1.error  = (out.error & ~out.busy) | expired_c;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_generic_bus_arbiter
// Directed bench for generic_bus_arbiter. Inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge. The downstream RAM is
// driven directly from the stimulus. The timeout scenario runs only when
// GENERIC_BUS_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_generic_bus_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        grant_owner;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    generic_bus_arbiter_if #(.BLOCK_SIZE(1)) req0_if ();
    generic_bus_arbiter_if #(.BLOCK_SIZE(1)) req1_if ();
    generic_bus_arbiter_if #(.BLOCK_SIZE(1)) out_if ();

    generic_bus_arbiter #(
        .BLOCK_SIZE (1)
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req0        (req0_if),
        .req1        (req1_if),
        .out         (out_if),
        .grant_owner (grant_owner)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        req0_if.addr = '0; req0_if.ren = 1'b0; req0_if.wen = 1'b0;
        req0_if.wdata = '0; req0_if.byte_en = '0;
        req1_if.addr = '0; req1_if.ren = 1'b0; req1_if.wen = 1'b0;
        req1_if.wdata = '0; req1_if.byte_en = '0;
        out_if.busy = 1'b0; out_if.rdata = '0; out_if.error = 1'b0;
    endtask

    // Ends 1 unit after a rising edge with reset released.
    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        step();
        step();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b1;
        clear_inputs();
        #3 nRST = 1'b0;
        #1;
        // Reset state
        check_eq("rst_out_ren",   64'(out_if.ren),     64'h0);
        check_eq("rst_out_addr",  64'(out_if.addr),    64'h0);
        check_eq("rst_req0_busy", 64'(req0_if.busy),   64'h1);
        check_eq("rst_req1_busy", 64'(req1_if.busy),   64'h1);
        check_eq("rst_owner",     64'(grant_owner),    64'h0);
        step();
        step();
        nRST = 1'b1;

        // Single read from req0, RAM busy for 3 grant cycles
        req0_if.ren = 1'b1; req0_if.addr = 32'h100; out_if.busy = 1'b1;
        mid();
        check_eq("t1_idle_ren",   64'(out_if.ren),   64'h0);
        check_eq("t1_idle_busy0", 64'(req0_if.busy), 64'h1);
        step(); mid();
        check_eq("t1_g_addr",   64'(out_if.addr),  64'h100);
        check_eq("t1_g_ren",    64'(out_if.ren),   64'h1);
        check_eq("t1_g_busy0",  64'(req0_if.busy), 64'h1);
        check_eq("t1_g_busy1",  64'(req1_if.busy), 64'h1);
        check_eq("t1_g_owner",  64'(grant_owner),  64'h0);
        step(); mid();
        step(); mid();
        check_eq("t1_wait_busy0", 64'(req0_if.busy), 64'h1);
        step();
        out_if.busy = 1'b0; out_if.rdata = 32'hDEADBEEF;
        mid();
        check_eq("t1_done_busy0",  64'(req0_if.busy),  64'h0);
        check_eq("t1_done_rdata0", 64'(req0_if.rdata), 64'hDEADBEEF);
        check_eq("t1_done_busy1",  64'(req1_if.busy),  64'h1);
        check_eq("t1_done_rdata1", 64'(req1_if.rdata), 64'h0);
        step();
        req0_if.ren = 1'b0; out_if.rdata = '0;
        mid();
        check_eq("t1_after_ren",   64'(out_if.ren),   64'h0);
        check_eq("t1_after_busy0", 64'(req0_if.busy), 64'h1);

        // Simultaneous requests after reset: req0 first, then req1 write
        do_reset();
        req0_if.ren = 1'b1; req0_if.addr = 32'h200;
        req1_if.wen = 1'b1; req1_if.addr = 32'h300;
        req1_if.wdata = 32'h12345678; req1_if.byte_en = 4'b0011;
        mid();
        check_eq("t2_idle_wen", 64'(out_if.wen), 64'h0);
        step(); mid();
        check_eq("t2_g0_owner", 64'(grant_owner),  64'h0);
        check_eq("t2_g0_addr",  64'(out_if.addr),  64'h200);
        check_eq("t2_g0_wen",   64'(out_if.wen),   64'h0);
        check_eq("t2_g0_busy0", 64'(req0_if.busy), 64'h0);
        check_eq("t2_g0_busy1", 64'(req1_if.busy), 64'h1);
        step();
        req0_if.ren = 1'b0;
        mid();
        check_eq("t2_gap_wen",   64'(out_if.wen),   64'h0);
        check_eq("t2_gap_busy1", 64'(req1_if.busy), 64'h1);
        step(); mid();
        check_eq("t2_g1_owner", 64'(grant_owner),    64'h1);
        check_eq("t2_g1_addr",  64'(out_if.addr),    64'h300);
        check_eq("t2_g1_wen",   64'(out_if.wen),     64'h1);
        check_eq("t2_g1_wdata", 64'(out_if.wdata),   64'h12345678);
        check_eq("t2_g1_be",    64'(out_if.byte_en), 64'h3);
        check_eq("t2_g1_busy1", 64'(req1_if.busy),   64'h0);
        step();
        clear_inputs();

        // Both hold requests: grants alternate 0,1,0,1,0,1
        do_reset();
        req0_if.ren = 1'b1; req0_if.addr = 32'h400;
        req1_if.ren = 1'b1; req1_if.addr = 32'h500;
        for (int t = 0; t < 6; t++) begin
            mid();
            check_eq($sformatf("t3_idle%0d_ren", t), 64'(out_if.ren), 64'h0);
            step(); mid();
            check_eq($sformatf("t3_owner%0d", t), 64'(grant_owner), 64'(t % 2));
            check_eq($sformatf("t3_addr%0d", t), 64'(out_if.addr),
                     (t % 2 == 1) ? 64'h500 : 64'h400);
            check_eq($sformatf("t3_done%0d", t),
                     64'((t % 2 == 1) ? req1_if.busy : req0_if.busy), 64'h0);
            step();
        end
        clear_inputs();

        // req1 drops wen mid-transaction; pending req0 granted next
        do_reset();
        req1_if.wen = 1'b1; req1_if.addr = 32'h600; req1_if.wdata = 32'hCAFE;
        req1_if.byte_en = 4'hF; out_if.busy = 1'b1;
        mid();
        step(); mid();
        check_eq("t4_g1_wen",   64'(out_if.wen),  64'h1);
        check_eq("t4_g1_owner", 64'(grant_owner), 64'h1);
        step();
        req1_if.wen = 1'b0; req0_if.ren = 1'b1; req0_if.addr = 32'h700;
        mid();
        check_eq("t4_abort_wen",   64'(out_if.wen),   64'h0);
        check_eq("t4_abort_ren",   64'(out_if.ren),   64'h0);
        check_eq("t4_abort_busy0", 64'(req0_if.busy), 64'h1);
        step(); mid();
        check_eq("t4_idle_ren", 64'(out_if.ren), 64'h0);
        step(); mid();
        check_eq("t4_g0_addr",  64'(out_if.addr), 64'h700);
        check_eq("t4_g0_ren",   64'(out_if.ren),  64'h1);
        check_eq("t4_g0_owner", 64'(grant_owner), 64'h0);
        step();
        out_if.busy = 1'b0;
        mid();
        check_eq("t4_g0_done", 64'(req0_if.busy), 64'h0);
        step();
        clear_inputs();

        // Asynchronous reset during GRANT1, then tie goes to req0
        do_reset();
        req1_if.wen = 1'b1; req1_if.addr = 32'h800; out_if.busy = 1'b1;
        mid();
        step(); mid();
        check_eq("t5_g1_wen", 64'(out_if.wen), 64'h1);
        #2 nRST = 1'b0;
        #1;
        check_eq("t5_arst_wen",   64'(out_if.wen),   64'h0);
        check_eq("t5_arst_ren",   64'(out_if.ren),   64'h0);
        check_eq("t5_arst_busy1", 64'(req1_if.busy), 64'h1);
        check_eq("t5_arst_busy0", 64'(req0_if.busy), 64'h1);
        check_eq("t5_arst_owner", 64'(grant_owner),  64'h0);
        step();
        nRST = 1'b1;
        req0_if.ren = 1'b1; req0_if.addr = 32'h900; out_if.busy = 1'b0;
        mid();
        check_eq("t5_idle_wen", 64'(out_if.wen), 64'h0);
        step(); mid();
        check_eq("t5_tie_owner", 64'(grant_owner), 64'h0);
        check_eq("t5_tie_addr",  64'(out_if.addr), 64'h900);
        check_eq("t5_tie_ren",   64'(out_if.ren),  64'h1);
        step();
        req0_if.ren = 1'b0;
        mid();
        check_eq("t5_gap_wen", 64'(out_if.wen), 64'h0);
        step(); mid();
        check_eq("t5_g1_owner", 64'(grant_owner), 64'h1);
        check_eq("t5_g1_addr",  64'(out_if.addr), 64'h800);
        check_eq("t5_g1_wen",   64'(out_if.wen),  64'h1);
        step();
        clear_inputs();

`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
        // RAM busy stuck high: timeout on the 8th grant cycle
        do_reset();
        req0_if.ren = 1'b1; req0_if.addr = 32'hA00; out_if.busy = 1'b1;
        mid();
        for (int k = 1; k <= 8; k++) begin
            step(); mid();
            if (k == 7) begin
                check_eq("t6_c7_busy",  64'(req0_if.busy),  64'h1);
                check_eq("t6_c7_error", 64'(req0_if.error), 64'h0);
            end
            if (k == 8) begin
                check_eq("t6_to_busy",  64'(req0_if.busy),  64'h0);
                check_eq("t6_to_error", 64'(req0_if.error), 64'h1);
                check_eq("t6_to_ren",   64'(out_if.ren),    64'h0);
            end
        end
        step();
        out_if.busy = 1'b0;
        mid();
        check_eq("t6_idle_busy", 64'(req0_if.busy), 64'h1);
        step(); mid();
        check_eq("t6_re_ren",   64'(out_if.ren),    64'h1);
        check_eq("t6_re_busy",  64'(req0_if.busy),  64'h0);
        check_eq("t6_re_error", 64'(req0_if.error), 64'h0);
        step();
        clear_inputs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
